// File: rtl/mod_counter_sequencer_if.sv
// Control/status bundle for mod_counter_sequencer: run requests and configuration
// from the control master, plus count, pulses and status back from the sequencer.
interface mod_counter_sequencer_if #(
    parameter int WIDTH = 3,
    parameter int CW    = 8
);
    logic             start;
    logic [WIDTH:0]   mod_val;
    logic [CW-1:0]    wraps;
    logic             up;
    logic             pause;
    logic             abort;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic [CW-1:0]    wrap_cnt;
    logic             busy;
    logic             done;
    logic             cfg_err;

    modport master (
        output start, mod_val, wraps, up, pause, abort,
        input  count, tc, wrap_cnt, busy, done, cfg_err
    );

    modport slave (
        input  start, mod_val, wraps, up, pause, abort,
        output count, tc, wrap_cnt, busy, done, cfg_err
    );
endinterface

// File: rtl/mod_counter_sequencer.sv
// Programmable modulo-N counter that runs a requested number of full wraps with
// start/done handshake, up/down direction, pause, abort and configuration checking.
module mod_counter_sequencer #(
    parameter int WIDTH = 3,
    parameter int CW    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    mod_counter_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [WIDTH:0]   N_ONE = (WIDTH+1)'(1);
    localparam logic [WIDTH:0]   N_MIN = (WIDTH+1)'(2);
    localparam logic [WIDTH:0]   N_MAX = {1'b1, {WIDTH{1'b0}}};
    localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);
    localparam logic [CW-1:0]    W_ONE = CW'(1);

    // Modulus must lie in 2..2^WIDTH and at least one wrap must be requested.
    function automatic logic cfg_legal(input logic [WIDTH:0] n, input logic [CW-1:0] w);
        return (n >= N_MIN) && (n <= N_MAX) && (w != {CW{1'b0}});
    endfunction

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [CW-1:0]    wrap_cnt_q;
    logic [CW-1:0]    wraps_q;
    logic [WIDTH:0]   n_q;
    logic             up_q;
    logic             tc_q;
    logic             done_q;
    logic             busy_q;
    logic             cfg_err_q;

    logic [WIDTH-1:0] top_s;
    logic [WIDTH-1:0] start_val_s;
    logic [WIDTH-1:0] step_d;
    logic [CW-1:0]    wrap_cnt_d;
    logic             at_term_s;
    logic             last_wrap_s;
    logic             start_legal_s;
    logic [WIDTH-1:0] load_val_s;

    // N-1 always fits in WIDTH bits because N never exceeds 2^WIDTH.
    assign top_s         = WIDTH'(n_q - N_ONE);
    assign start_val_s   = up_q ? {WIDTH{1'b0}} : top_s;
    assign at_term_s     = up_q ? (count_q == top_s) : (count_q == {WIDTH{1'b0}});
    assign step_d        = up_q ? (count_q + C_ONE) : (count_q - C_ONE);
    assign wrap_cnt_d    = wrap_cnt_q + W_ONE;
    assign last_wrap_s   = (wrap_cnt_d == wraps_q);
    assign start_legal_s = cfg_legal(bus.mod_val, bus.wraps);
    assign load_val_s    = bus.up ? {WIDTH{1'b0}} : WIDTH'(bus.mod_val - N_ONE);

    // Sequencer FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            count_q    <= {WIDTH{1'b0}};
            wrap_cnt_q <= {CW{1'b0}};
            wraps_q    <= {CW{1'b0}};
            n_q        <= {(WIDTH+1){1'b0}};
            up_q       <= 1'b0;
            tc_q       <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            tc_q      <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        if (start_legal_s) begin
                            n_q        <= bus.mod_val;
                            wraps_q    <= bus.wraps;
                            up_q       <= bus.up;
                            count_q    <= load_val_s;
                            wrap_cnt_q <= {CW{1'b0}};
                            busy_q     <= 1'b1;
                            state_q    <= ST_RUN;
                        end else begin
                            cfg_err_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        count_q <= {WIDTH{1'b0}};
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (bus.pause) begin
                        state_q <= ST_HOLD;
                    end else if (at_term_s) begin
                        count_q    <= start_val_s;
                        tc_q       <= 1'b1;
                        wrap_cnt_q <= wrap_cnt_d;
                        if (last_wrap_s) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        count_q <= step_d;
                    end
                end
                ST_HOLD: begin
                    // Leaving HOLD costs one edge; counting resumes on the next one.
                    if (bus.abort) begin
                        count_q <= {WIDTH{1'b0}};
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!bus.pause) begin
                        state_q <= ST_RUN;
                    end
                end
                default: begin
                    count_q <= {WIDTH{1'b0}};
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.count    = count_q;
    assign bus.tc       = tc_q;
    assign bus.wrap_cnt = wrap_cnt_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_mod_counter_sequencer.sv
// Directed bench for mod_counter_sequencer: wrap sequences, config errors,
// pause, abort, mid-run reset, with hand-computed expectations.
module tb_mod_counter_sequencer;
    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   e;

    mod_counter_sequencer_if #(.WIDTH(3), .CW(8)) bus_if ();

    mod_counter_sequencer #(.WIDTH(3), .CW(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int c, input int t, input int w,
                              input int b, input int d);
        check_val({tag, ".count"},    32'(bus_if.count),    c);
        check_val({tag, ".tc"},       32'(bus_if.tc),       t);
        check_val({tag, ".wrap_cnt"}, 32'(bus_if.wrap_cnt), w);
        check_val({tag, ".busy"},     32'(bus_if.busy),     b);
        check_val({tag, ".done"},     32'(bus_if.done),     d);
    endtask

    task automatic launch(input int n, input int w, input logic u);
        bus_if.start   = 1'b1;
        bus_if.mod_val = 4'(n);
        bus_if.wraps   = 8'(w);
        bus_if.up      = u;
        tick();
        bus_if.start   = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus_if.start = 1'b0; bus_if.mod_val = 4'd0; bus_if.wraps = 8'd0;
        bus_if.up = 1'b0; bus_if.pause = 1'b0; bus_if.abort = 1'b0;
        tick(); tick();
        rst = 1'b0;
        expect_out("reset", 0, 0, 0, 0, 0);
        check_val("reset.cfg_err", 32'(bus_if.cfg_err), 0);

        // Up count, N=5, two wraps: done at E10.
        launch(5, 2, 1'b1);
        expect_out("up_e0", 0, 0, 0, 1, 0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            expect_out($sformatf("up_e%0d", k), k % 5, (k % 5 == 0) ? 1 : 0, k / 5,
                       (k < 10) ? 1 : 0, (k == 10) ? 1 : 0);
        end
        tick();
        expect_out("up_after", 0, 0, 2, 0, 0);

        // Down count, N=5, one wrap: 4,3,2,1,0,4.
        launch(5, 1, 1'b0);
        expect_out("dn_e0", 4, 0, 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            expect_out($sformatf("dn_e%0d", k), (k < 5) ? 4 - k : 4, (k == 5) ? 1 : 0,
                       (k == 5) ? 1 : 0, (k < 5) ? 1 : 0, (k == 5) ? 1 : 0);
        end
        tick();
        expect_out("dn_after", 4, 0, 1, 0, 0);

        // Illegal configurations pulse cfg_err once and change nothing.
        begin
            int bad_n [4] = '{1, 0, 9, 5};
            int bad_w [4] = '{3, 3, 3, 0};
            for (int i = 0; i < 4; i++) begin
                launch(bad_n[i], bad_w[i], 1'b1);
                check_val($sformatf("cfg%0d.cfg_err", i), 32'(bus_if.cfg_err), 1);
                expect_out($sformatf("cfg%0d", i), 4, 0, 1, 0, 0);
                tick();
                check_val($sformatf("cfg%0d.cfg_err_low", i), 32'(bus_if.cfg_err), 0);
            end
        end

        // N=8, three wraps, pause for 4 cycles at count 6: done at E29 instead of E24.
        launch(8, 3, 1'b1);
        e = 0;
        for (int k = 0; k < 6; k++) begin tick(); e++; end
        expect_out("pz_at6", 6, 0, 0, 1, 0);
        bus_if.pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(); e++;
            expect_out($sformatf("pz_hold%0d", k), 6, 0, 0, 1, 0);
        end
        bus_if.pause = 1'b0;
        tick(); e++;
        expect_out("pz_exit", 6, 0, 0, 1, 0);
        tick(); e++;
        expect_out("pz_resume", 7, 0, 0, 1, 0);
        while (bus_if.done !== 1'b1 && e < 60) begin tick(); e++; end
        check_val("pz_done_edge", 32'(e), 29);
        expect_out("pz_done", 0, 1, 3, 0, 1);

        // N=6, four wraps; a start while busy is ignored; abort at wrap_cnt=2, count=3.
        launch(6, 4, 1'b1);
        e = 0;
        tick(); tick(); e = 2;
        bus_if.start = 1'b1; bus_if.mod_val = 4'd3; bus_if.wraps = 8'd1; bus_if.up = 1'b0;
        tick(); e++;
        bus_if.start = 1'b0;
        while (e < 15) begin tick(); e++; end
        expect_out("ab_pre", 3, 0, 2, 1, 0);
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        expect_out("ab_run", 0, 0, 2, 0, 0);

        // Abort while in HOLD.
        launch(6, 4, 1'b1);
        tick(); tick(); tick();
        bus_if.pause = 1'b1;
        tick(); tick();
        expect_out("ab_hold_pre", 3, 0, 0, 1, 0);
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0; bus_if.pause = 1'b0;
        expect_out("ab_hold", 0, 0, 0, 0, 0);

        // Abort coinciding with the final wrap: abort wins.
        launch(2, 1, 1'b1);
        tick();
        expect_out("ab_fin_pre", 1, 0, 0, 1, 0);
        bus_if.abort = 1'b1;
        tick();
        bus_if.abort = 1'b0;
        expect_out("ab_fin", 0, 0, 0, 0, 0);

        // Reset mid-run at count=2, wrap_cnt=1, then a fresh N=3 single-wrap run.
        launch(4, 3, 1'b1);
        for (int k = 0; k < 6; k++) tick();
        expect_out("rst_pre", 2, 0, 1, 1, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("rst_mid", 0, 0, 0, 0, 0);
        check_val("rst_mid.cfg_err", 32'(bus_if.cfg_err), 0);
        launch(3, 1, 1'b1);
        expect_out("post_e0", 0, 0, 0, 1, 0);
        tick();
        expect_out("post_e1", 1, 0, 0, 1, 0);
        tick();
        expect_out("post_e2", 2, 0, 0, 1, 0);
        tick();
        expect_out("post_e3", 0, 1, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
